// File: rtl/apdtimer_pkg.sv
// Shared definitions for the apdtimer_multi time-tagger: record width,
// field offsets and the record layout used by firmware-side decoding.
package apdtimer_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int MAX_TS_WIDTH = 48;
    localparam int TS_LSB       = 0;

    function automatic int REC_W(input int channels, input int ts_width);
        return ts_width + channels + 1;
    endfunction

    function automatic int MASK_LSB(input int ts_width);
        return TS_LSB + ts_width;
    endfunction

    function automatic int WRAP_BIT(input int channels, input int ts_width);
        return MASK_LSB(ts_width) + channels;
    endfunction

    // Widest record; narrower builds use the low CHANNELS/TS_WIDTH bits of each field.
    typedef struct packed {
        logic                    wrap;
        logic [MAX_CHANNELS-1:0] mask;
        logic [MAX_TS_WIDTH-1:0] ts;
    } record_t;

endpackage

// File: rtl/tag_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module tag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the read port is gated by empty
    // so stale or uninitialised entries never reach the output.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/apdtimer_multi.sv
// Multi-channel photon time-tagger: synchronises detector pulses, stamps rising
// edges with a free-running counter and queues one record per active cycle.
module apdtimer_multi
    import apdtimer_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int TS_WIDTH   = 36,
    parameter int FIFO_DEPTH = 16,
    parameter int LOST_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 operate,
    input  logic                                 reset_counter,
    input  logic [CHANNELS-1:0]                  chan_enable,
    input  logic [CHANNELS-1:0]                  detectors,
    output logic                                 data_valid,
    input  logic                                 data_ready,
    output logic [REC_W(CHANNELS, TS_WIDTH)-1:0] data,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
    output logic [LOST_WIDTH-1:0]                lost_count,
    output logic                                 overflow
);
    localparam int REC_WIDTH = REC_W(CHANNELS, TS_WIDTH);

    logic [CHANNELS-1:0]   edge_flag;
    logic [TS_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LOST_WIDTH-1:0] lost_q, lost_d;
    logic                  ovf_q, ovf_d;
    logic                  wrap;
    logic                  push, pop, drop;
    logic                  fifo_full, fifo_empty;
    logic [REC_WIDTH-1:0]  wr_rec;

    // sync_q[0..1] form the metastability synchroniser, sync_q[2] the edge history.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [2:0] sync_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sync_q <= '0;
            else          sync_q <= {sync_q[1:0], detectors[i]};
        end

        assign edge_flag[i] = sync_q[1] & ~sync_q[2] & chan_enable[i] & operate;
    end

    assign wrap = operate & ~reset_counter & (&cnt_q);
    assign push = wrap | (|edge_flag);
    assign pop  = data_valid & data_ready;
    assign drop = push & fifo_full & ~pop;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (reset_counter) cnt_d = '0;
        else if (operate)  cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        wr_rec                                = '0;
        wr_rec[WRAP_BIT(CHANNELS, TS_WIDTH)]  = wrap;
        wr_rec[MASK_LSB(TS_WIDTH) +: CHANNELS] = edge_flag;
        wr_rec[TS_LSB +: TS_WIDTH]            = cnt_q;
    end

    always_comb begin
        lost_d = lost_q;
        ovf_d  = ovf_q;
        if (reset_counter) begin
            lost_d = '0;
            ovf_d  = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (lost_q != '1) lost_d = lost_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            lost_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lost_q <= lost_d;
            ovf_q  <= ovf_d;
        end
    end

    tag_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (push),
        .wr_data_i (wr_rec),
        .pop_i     (pop),
        .rd_data_o (data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign data_valid = ~fifo_empty;
    assign lost_count = lost_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_apdtimer_multi.sv
// Directed bench for apdtimer_multi: a 4-deep/36-bit instance for tagging,
// backpressure and clears, and an 8-bit-timestamp instance for wrap records.
module tb_apdtimer_multi;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        operate, reset_counter, data_ready;
    logic [3:0]  chan_enable, detectors;
    logic        data_valid, overflow;
    logic [40:0] data;
    logic [2:0]  fifo_level;
    logic [15:0] lost_count;

    logic        w_operate, w_reset_counter, w_ready;
    logic [3:0]  w_chan_enable, w_detectors;
    logic        w_valid, w_overflow;
    logic [12:0] w_data;
    logic [4:0]  w_level;
    logic [15:0] w_lost;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [35:0] cnt;
    logic [35:0] t0;
    logic [40:0] exp_r [6];
    logic [40:0] exp5;
    logic [3:0]  masks [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    always #5 clk = ~clk;

    apdtimer_multi #(
        .CHANNELS(4), .TS_WIDTH(36), .FIFO_DEPTH(4), .LOST_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .operate(operate), .reset_counter(reset_counter),
        .chan_enable(chan_enable), .detectors(detectors), .data_valid(data_valid),
        .data_ready(data_ready), .data(data), .fifo_level(fifo_level),
        .lost_count(lost_count), .overflow(overflow)
    );

    apdtimer_multi #(
        .CHANNELS(4), .TS_WIDTH(8), .FIFO_DEPTH(16), .LOST_WIDTH(16)
    ) dut_w (
        .clk(clk), .reset_n(reset_n), .operate(w_operate), .reset_counter(w_reset_counter),
        .chan_enable(w_chan_enable), .detectors(w_detectors), .data_valid(w_valid),
        .data_ready(w_ready), .data(w_data), .fifo_level(w_level),
        .lost_count(w_lost), .overflow(w_overflow)
    );

    function automatic logic [40:0] rec_a(input logic w, input logic [3:0] m, input logic [35:0] ts);
        return {w, m, ts};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; the model counter mirrors what the timestamp should do.
    task automatic tick();
        @(negedge clk);
        if (!reset_n)          cnt = '0;
        else if (reset_counter) cnt = '0;
        else if (operate)       cnt = cnt + 1'b1;
    endtask

    task automatic pulse(input logic [3:0] m);
        detectors = m;
        tick();
        detectors = 4'b0000;
        tick();
    endtask

    task automatic pop1();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; operate = 1'b0; reset_counter = 1'b0; data_ready = 1'b0;
        chan_enable = 4'hF; detectors = 4'h0;
        w_operate = 1'b0; w_reset_counter = 1'b0; w_ready = 1'b0;
        w_chan_enable = 4'hF; w_detectors = 4'h0;
        cnt = '0;
        repeat (3) tick();
        check("rst_valid", data_valid, 0);
        check("rst_data", data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_lost", lost_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_w_valid", w_valid, 0);

        reset_n = 1'b1;
        operate = 1'b1;

        // Single 4-cycle pulse on ch1 sampled first while counter=100.
        while (cnt != 36'd100) tick();
        detectors = 4'b0010;
        tick(); tick();
        check("lat_not_yet", data_valid, 0);
        tick();
        check("lat_valid", data_valid, 1);
        check("single_rec", data, rec_a(1'b0, 4'b0010, 36'd102));
        tick();
        detectors = 4'b0000;
        repeat (4) tick();
        check("single_once", fifo_level, 1);
        pop1();
        check("pop_empty_level", fifo_level, 0);
        check("pop_empty_data", data, 0);

        // ch0 and ch3 together coalesce into one record.
        t0 = cnt;
        detectors = 4'b1001;
        repeat (3) tick();
        check("coalesce_rec", data, rec_a(1'b0, 4'b1001, t0 + 36'd2));
        detectors = 4'b0000;
        repeat (3) tick();
        check("coalesce_once", fifo_level, 1);
        pop1();

        // Disabled channel produces nothing.
        chan_enable = 4'b0111;
        detectors = 4'b1000;
        repeat (4) tick();
        detectors = 4'b0000;
        repeat (3) tick();
        check("masked_ch3", fifo_level, 0);
        chan_enable = 4'hF;

        // Six pulses into a 4-deep FIFO with the consumer stalled.
        for (int k = 0; k < 6; k++) begin
            exp_r[k] = rec_a(1'b0, masks[k], cnt + 36'd2);
            pulse(masks[k]);
        end
        repeat (2) tick();
        check("bp_level", fifo_level, 4);
        check("bp_lost", lost_count, 2);
        check("bp_ovf", overflow, 1);
        check("bp_head", data, exp_r[0]);
        repeat (3) tick();
        check("bp_stable", data, exp_r[0]);
        data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_%0d", k), data, exp_r[k]);
            tick();
        end
        data_ready = 1'b0;
        check("drain_level", fifo_level, 0);
        check("drain_valid", data_valid, 0);

        // Full FIFO: push and pop on the same edge keep the record.
        for (int k = 0; k < 4; k++) begin
            exp_r[k] = rec_a(1'b0, masks[k], cnt + 36'd2);
            pulse(masks[k]);
        end
        repeat (2) tick();
        check("full_level", fifo_level, 4);
        t0 = cnt;
        detectors = 4'b0100;
        tick(); tick();
        exp5 = rec_a(1'b0, 4'b0100, t0 + 36'd2);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        detectors = 4'b0000;
        check("fullpop_level", fifo_level, 4);
        check("fullpop_lost", lost_count, 2);
        check("fullpop_head", data, exp_r[1]);

        // reset_counter at counter=500 with two records queued.
        data_ready = 1'b1;
        tick(); tick();
        data_ready = 1'b0;
        check("rc_pre_level", fifo_level, 2);
        while (cnt != 36'd499) tick();
        detectors = 4'b0100;
        tick();
        reset_counter = 1'b1;
        tick();
        reset_counter = 1'b0;
        tick();
        detectors = 4'b0000;
        check("rc_lost", lost_count, 0);
        check("rc_ovf", overflow, 0);
        check("rc_level", fifo_level, 3);
        check("rc_head", data, exp_r[3]);
        pop1();
        check("rc_kept", data, exp5);
        pop1();
        check("rc_ts0", data, rec_a(1'b0, 4'b0100, 36'd0));

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 5; k++) pulse(masks[k]);
        repeat (2) tick();
        check("burst_lost", lost_count, 2);
        detectors = 4'b0011;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", data_valid, 0);
        check("arst_data", data, 0);
        check("arst_level", fifo_level, 0);
        check("arst_lost", lost_count, 0);
        check("arst_ovf", overflow, 0);
        detectors = 4'b0000;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("arst_after_level", fifo_level, 0);
        check("arst_after_lost", lost_count, 0);

        // 8-bit timestamp: wrap record every 256 operating cycles.
        w_operate = 1'b1;
        repeat (255) tick();
        check("wrap_early", w_level, 0);
        tick();
        check("wrap_level", w_level, 1);
        check("wrap_rec", w_data, {1'b1, 4'b0000, 8'hFF});
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        repeat (252) tick();
        w_detectors = 4'b0101;
        repeat (3) tick();
        w_detectors = 4'b0000;
        check("wrap_edge_level", w_level, 1);
        check("wrap_edge_rec", w_data, {1'b1, 4'b0101, 8'hFF});
        check("wrap_lost", w_lost, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apdtimer_multi.md
# apdtimer_multi

Parametrised photon time-tagger front end: synchronises CHANNELS asynchronous detector pulses, rising-edge detects them, stamps each with a free-running timestamp and pushes one record per active cycle into an on-block FIFO. Records drain to the host/readout path over a valid/ready handshake. Successor to the fixed four-channel, unbuffered tagger. Adds:
- per-channel enable mask
- counter-wrap records
- FIFO buffering with backpressure
- dropped-record accounting

## Interface
- CHANNELS, 4: number of detector inputs (1–16)
- TS_WIDTH, 36: timestamp counter width (8–48)
- FIFO_DEPTH, 16: record FIFO entries (power of two, ≥2)
- LOST_WIDTH, 16: dropped-record counter width
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- operate  in  1  enables counting and event capture
- reset_counter  in  1  synchronous clear of timestamp, lost_count, overflow
- chan_enable  in  CHANNELS  per-channel capture enable
- detectors  in  CHANNELS  asynchronous detector pulses
- data_valid  out  1  record available on data
- data_ready  in  1  consumer accepts record when data_valid & data_ready
- data  out  TS_WIDTH+CHANNELS+1  record {wrap, mask[CHANNELS-1:0], ts[TS_WIDTH-1:0]}
- fifo_level  out  $clog2(FIFO_DEPTH)+1  stored records
- lost_count  out  LOST_WIDTH  saturating count of dropped records
- overflow  out  1  sticky: at least one record dropped

## Operation
- Reset values: data_valid=0, data=0, fifo_level=0, lost_count=0, overflow=0, counter=0, synchronisers=0.
- Per channel: 2-flop synchroniser, then third flop. Edge flag = sync2 & ~sync3 & chan_enable & operate.
  - A pulse held high for N cycles yields exactly one edge.
  - A pulse shorter than one clock period may be missed.
- Counter increments every cycle operate=1 and holds when operate=0. reset_counter has priority: counter←0.
- Wrap: in the cycle the counter holds all-ones and increments, wrap=1.
- Record generation, in a cycle where mask≠0 or wrap=1:
  - record = {wrap, mask, ts}; ts is the counter value in that cycle.
  - Simultaneous edges on several channels coalesce into one record.
  - A wrap and an edge in the same cycle form one record with both fields set.
- FIFO push:
  - Accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the record is dropped: lost_count increments (saturating at all-ones) and overflow←1.
- FIFO pop: on data_valid & data_ready. data must remain stable while data_valid=1 and data_ready=0.
- reset_counter:
  - Does not flush the FIFO or synchronisers.
  - A record already generated keeps its pre-clear ts.
- reset_n asserted mid-operation: all state clears immediately. Records in flight are lost and not counted.

## Timing
- Detector rising edge sampled high first at clock edge E0:
  - sync1 at E0, sync2 at E1.
  - Edge flag high in the cycle after E1; ts = counter value in that cycle.
  - Record written at E2.
  - data_valid=1 after E2 when the FIFO was empty: latency 2 edges, first-word-fall-through.
- Throughput: one record per cycle in, one out.
- fifo_level updates on the same edge as the push/pop; push and pop together leave it unchanged.
- lost_count and overflow update on the edge of the dropped push.
- reset_counter sampled at edge Ec: counter=0 during the cycle after Ec. A record generated in that cycle has ts=0.

## Structure
- Package apdtimer_pkg:
  - REC_W(CHANNELS, TS_WIDTH) function
  - field offsets: TS_LSB, MASK_LSB, WRAP_BIT
  - record struct typedef
- Sub-module tag_fifo:
  - synchronous FWFT FIFO with parameters WIDTH, DEPTH
  - outputs full, empty, level
  - full-with-pop accepts push
- Synchronisers, edge detect, counter and accounting in the top level, with a generate loop per channel.

## Test plan
- Single pulse on ch1 (4-cycle high) at counter=100, operate=1, all enabled → exactly one record {0, 4'b0010, ts=102} with data_valid 2 edges after first high sample.
- ch0 and ch3 rise on the same edge → one record, mask=4'b1001; chan_enable=4'b0111 with ch3 pulse → no record.
- TS_WIDTH=8, operate held, no pulses → wrap record {1, 0, 8'hFF} every 256 cycles; pulse landing in the wrap cycle → {1, mask, 8'hFF}.
- data_ready=0, FIFO_DEPTH=4, 6 distinct pulses → fifo_level=4, lost_count=2, overflow=1. Then data_ready=1 → the 4 oldest records drain in order and data is stable while stalled.
- FIFO full with data_ready=1 and a new event in the same cycle → push accepted, lost_count unchanged, fifo_level stays 4.
- reset_counter pulse at counter=500 with 2 records queued → counter 0, lost_count/overflow clear, queued records intact. reset_n asserted mid-burst → all outputs 0 asynchronously.
